// File: rtl/sqrt_req_ctrl.sv
// Flow-controlled front end for the combinational 8-bit root unit:
// one request in flight, settle window, exactness check, response FIFO.
module sqrt_req_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_radicand,
  output logic [WIDTH-1:0] sqrt_radicand,
  output logic             sqrt_enable,
  input  logic [WIDTH-1:0] sqrt_root,
  input  logic             sqrt_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_radicand,
  output logic [WIDTH-1:0] rsp_root,
  output logic             rsp_exact,
  output logic             busy
);

  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DW  = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t           r_state;
  logic [SCW-1:0]   r_settle;
  logic [WIDTH-1:0] r_rad;
  logic             r_live;

  logic [WIDTH-1:0] r_mem_rad  [FIFO_DEPTH];
  logic [WIDTH-1:0] r_mem_root [FIFO_DEPTH];
  logic             r_mem_ex   [FIFO_DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_exact;
  logic             w_room;
  logic [DW-1:0]    w_sq;
  logic [WIDTH-1:0] w_root_q;
  logic             w_unused;

  // root unit's valid flag is not tied to our operation
  assign w_unused = sqrt_valid;

  assign w_sq     = DW'(sqrt_root) * DW'(sqrt_root);
  assign w_exact  = (w_sq == DW'(r_rad));
  assign w_root_q = w_exact ? sqrt_root : '0;

  assign w_room   = (r_cnt < CW'(FIFO_DEPTH));
  assign req_ready = r_live & (r_state == S_IDLE) & w_room;
  assign w_accept = req_valid & req_ready;
  assign w_push   = (r_state == S_CAPTURE);
  assign w_pop    = rsp_valid & rsp_ready;

  assign sqrt_radicand = r_rad;
  assign sqrt_enable   = (r_state != S_IDLE);
  assign busy          = (r_state != S_IDLE);

  assign rsp_valid    = (r_cnt != '0);
  assign rsp_radicand = rsp_valid ? r_mem_rad[r_rd]  : '0;
  assign rsp_root     = rsp_valid ? r_mem_root[r_rd] : '0;
  assign rsp_exact    = rsp_valid & r_mem_ex[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_settle <= '0;
      r_rad    <= '0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rad    <= req_radicand;
            r_settle <= SCW'(SETTLE_CYCLES - 1);
            r_state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_settle == '0) begin
            r_state <= S_CAPTURE;
          end else begin
            r_settle <= r_settle - SCW'(1);
          end
        end
        S_CAPTURE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // acceptance is gated on free space, so a push never meets a full FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_rad[i]  <= '0;
        r_mem_root[i] <= '0;
        r_mem_ex[i]   <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_mem_rad[r_wr]  <= r_rad;
        r_mem_root[r_wr] <= w_root_q;
        r_mem_ex[r_wr]   <= w_exact;
        r_wr             <= r_wr + PW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_req_ctrl.sv
// Directed bench for sqrt_req_ctrl with a behavioural floor-sqrt unit.
// Inputs driven and outputs sampled on the falling edge.
module tb_sqrt_req_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_radicand;
  logic [7:0] sqrt_radicand;
  logic       sqrt_enable;
  logic [7:0] sqrt_root;
  logic       sqrt_valid;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_radicand;
  logic [7:0] rsp_root;
  logic       rsp_exact;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sqrt_req_ctrl #(
    .WIDTH(8),
    .SETTLE_CYCLES(2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_radicand(req_radicand),
    .sqrt_radicand(sqrt_radicand),
    .sqrt_enable(sqrt_enable),
    .sqrt_root(sqrt_root),
    .sqrt_valid(sqrt_valid),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_radicand(rsp_radicand),
    .rsp_root(rsp_root),
    .rsp_exact(rsp_exact),
    .busy(busy)
  );

  // free-running floor-sqrt unit, valid whenever enabled
  always_comb begin
    sqrt_root = '0;
    for (int i = 0; i < 16; i++) begin
      if (i * i <= int'(sqrt_radicand)) sqrt_root = 8'(i);
    end
  end
  assign sqrt_valid = sqrt_enable;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input int rad, input int root,
                      input int ex);
    chk({tag, " valid"}, int'(rsp_valid), 1);
    chk({tag, " radicand"}, int'(rsp_radicand), rad);
    chk({tag, " root"}, int'(rsp_root), root);
    chk({tag, " exact"}, int'(rsp_exact), ex);
  endtask

  // offer rad until accepted, then wait until its result is pushed
  task automatic send(input int rad);
    bit got;
    got = 1'b0;
    req_valid    = 1'b1;
    req_radicand = 8'(rad);
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept", int'(got), 1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_chk(input string tag, input int rad, input int root,
                          input int ex);
    send(rad);
    head(tag, rad, root, ex);
    @(negedge clk);
    chk({tag, " popped"}, int'(rsp_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bp_rad [4];
    int bp_root[4];
    bp_rad  = '{25, 36, 64, 81};
    bp_root = '{5, 6, 8, 9};

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_radicand = '0;
    rsp_ready    = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst req_ready", int'(req_ready), 0);
    chk("rst enable", int'(sqrt_enable), 0);
    chk("rst sqrt_rad", int'(sqrt_radicand), 0);
    chk("rst rsp_valid", int'(rsp_valid), 0);
    chk("rst rsp_rad", int'(rsp_radicand), 0);
    chk("rst rsp_root", int'(rsp_root), 0);
    chk("rst rsp_exact", int'(rsp_exact), 0);
    chk("rst busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst req_ready", int'(req_ready), 1);
    chk("post rst busy", int'(busy), 0);
    chk("post rst rsp_valid", int'(rsp_valid), 0);

    // exact request, cycle by cycle
    rsp_ready    = 1'b1;
    req_valid    = 1'b1;
    req_radicand = 8'd49;
    @(negedge clk);
    req_valid = 1'b0;
    chk("49 t1 enable", int'(sqrt_enable), 1);
    chk("49 t1 busy", int'(busy), 1);
    chk("49 t1 req_ready", int'(req_ready), 0);
    chk("49 t1 sqrt_rad", int'(sqrt_radicand), 49);
    chk("49 t1 rsp_valid", int'(rsp_valid), 0);
    @(negedge clk);
    chk("49 t2 enable", int'(sqrt_enable), 1);
    chk("49 t2 rsp_valid", int'(rsp_valid), 0);
    @(negedge clk);
    chk("49 t3 enable", int'(sqrt_enable), 1);
    chk("49 t3 rsp_valid", int'(rsp_valid), 0);
    @(negedge clk);
    chk("49 t4 enable", int'(sqrt_enable), 0);
    chk("49 t4 busy", int'(busy), 0);
    chk("49 t4 req_ready", int'(req_ready), 1);
    chk("49 t4 sqrt_rad hold", int'(sqrt_radicand), 49);
    head("49", 49, 7, 1);
    @(negedge clk);
    chk("49 popped", int'(rsp_valid), 0);

    send_chk("50", 50, 0, 0);
    send_chk("0", 0, 0, 1);
    send_chk("225", 225, 15, 1);
    send_chk("255", 255, 0, 0);

    // backpressure: fill the FIFO, then hold a fifth request
    rsp_ready = 1'b0;
    send(16);
    send(25);
    send(36);
    send(64);
    req_valid    = 1'b1;
    req_radicand = 8'd81;
    repeat (4) @(negedge clk);
    chk("full req_ready", int'(req_ready), 0);
    chk("full busy", int'(busy), 0);
    head("full head", 16, 4, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("after pop req_ready", int'(req_ready), 1);
    head("after pop head", 25, 5, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("81 accepted busy", int'(busy), 1);
    chk("81 sqrt_rad", int'(sqrt_radicand), 81);
    repeat (3) @(negedge clk);
    chk("81 done req_ready", int'(req_ready), 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      head($sformatf("drain%0d", i), bp_rad[i], bp_root[i], 1);
      @(negedge clk);
    end
    chk("drain empty", int'(rsp_valid), 0);
    chk("drain req_ready", int'(req_ready), 1);

    // reset during SETTLE
    req_valid    = 1'b1;
    req_radicand = 8'd144;
    @(negedge clk);
    req_valid = 1'b0;
    chk("144 settle enable", int'(sqrt_enable), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst enable", int'(sqrt_enable), 0);
    chk("midrst busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst rsp_valid", int'(rsp_valid), 0);
    chk("midrst req_ready", int'(req_ready), 1);
    chk("midrst enable idle", int'(sqrt_enable), 0);

    send_chk("after midrst 196", 196, 14, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
